storage_arbiter: RTL and testbench

//  Shares the single storage_controller port between two requesters: instruction fetch (I) and vector/scalar data (D).

---
 rtl/storage_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_storage_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/storage_arbiter.sv
// Round-robin arbiter sharing one storage_controller port between instruction fetch (I)
// and data (D) requesters. Each access: grant, held BUSY window, one-cycle GAP.
module storage_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] EXT_BASE    = 32'h0100_0000,
    parameter int                TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_mode,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_be,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  memory_access,
    output logic                  memory_is_writing,
    output logic [ADDR_W-1:0]     addr,
    output logic [DATA_W-1:0]     d_in,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic                  external_storage_access,
    input  logic [DATA_W-1:0]     d_out,
    input  logic                  out_valid,
    output logic                  arb_idle
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;
    localparam int         CNT_W  = $clog2(TIMEOUT_CYC) + 1;
    localparam logic       OWN_I  = 1'b0;
    localparam logic       OWN_D  = 1'b1;

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_owner_q, last_owner_d;
    logic                owner_q, owner_d;
    logic                mem_access_q, mem_access_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic                ext_q, ext_d;
    logic                i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic                i_err_q, i_err_d, d_err_q, d_err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    logic                win_i, win_d, can_grant, done, cmp_err;
    logic                sel_we, sel_ext;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata, cmp_data;
    logic [DATA_W/8-1:0] sel_be;

    // On a tie the requester that did not own the port last time wins.
    assign win_i     = i_req && (!d_req || last_owner_q == OWN_D);
    assign win_d     = d_req && (!i_req || last_owner_q == OWN_I);
    assign can_grant = !rst && state_q == S_IDLE && !prog_mode;
    assign i_gnt     = can_grant && win_i;
    assign d_gnt     = can_grant && win_d;

    assign sel_we    = win_i ? i_we    : d_we;
    assign sel_addr  = win_i ? i_addr  : d_addr;
    assign sel_wdata = win_i ? i_wdata : d_wdata;
    assign sel_be    = win_i ? i_be    : d_be;
    assign sel_ext   = sel_addr >= EXT_BASE;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        mem_access_d = mem_access_q;
        mem_we_d     = mem_we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        ext_d        = ext_q;
        done         = 1'b0;
        cmp_err      = 1'b0;
        cmp_data     = '0;
        case (state_q)
            S_IDLE: begin
                if (i_gnt || d_gnt) begin
                    owner_d      = d_gnt ? OWN_D : OWN_I;
                    last_owner_d = d_gnt ? OWN_D : OWN_I;
                    if (sel_ext && sel_we) begin
                        state_d = S_ERR;
                    end else begin
                        state_d      = S_BUSY;
                        mem_access_d = 1'b1;
                        mem_we_d     = sel_we;
                        addr_d       = sel_addr;
                        wdata_d      = sel_wdata;
                        be_d         = sel_be;
                        ext_d        = sel_ext;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (out_valid || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d      = S_GAP;
                    done         = 1'b1;
                    cmp_err      = !out_valid;
                    cmp_data     = (out_valid && !mem_we_q) ? d_out : '0;
                    mem_access_d = 1'b0;
                    mem_we_d     = 1'b0;
                    addr_d       = '0;
                    wdata_d      = '0;
                    be_d         = '0;
                    ext_d        = 1'b0;
                end
            end
            S_ERR: begin
                state_d = S_GAP;
                done    = 1'b1;
                cmp_err = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        i_rvalid_d = done && owner_q == OWN_I;
        d_rvalid_d = done && owner_q == OWN_D;
        i_err_d    = i_rvalid_d && cmp_err;
        d_err_d    = d_rvalid_d && cmp_err;
        i_rdata_d  = i_rvalid_d ? cmp_data : '0;
        d_rdata_d  = d_rvalid_d ? cmp_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_owner_q <= OWN_D;
            owner_q      <= OWN_I;
            mem_access_q <= 1'b0;
            mem_we_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            ext_q        <= 1'b0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            mem_access_q <= mem_access_d;
            mem_we_q     <= mem_we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            ext_q        <= ext_d;
            i_rvalid_q   <= i_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign memory_access           = mem_access_q;
    assign memory_is_writing       = mem_we_q;
    assign addr                    = addr_q;
    assign d_in                    = wdata_q;
    assign mem_be                  = be_q;
    assign external_storage_access = ext_q;
    assign i_rvalid                = i_rvalid_q;
    assign d_rvalid                = d_rvalid_q;
    assign i_err                   = i_err_q;
    assign d_err                   = d_err_q;
    assign i_rdata                 = i_rdata_q;
    assign d_rdata                 = d_rdata_q;
    assign arb_idle                = state_q == S_IDLE;
endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter: the storage_controller side (out_valid/d_out)
// is driven by hand, cycle by cycle.
module tb_storage_arbiter;
    localparam logic [31:0] EXT = 32'h0100_0000;
    localparam int          TO  = 4096;

    logic        clk = 1'b0;
    logic        rst, prog_mode;
    logic        i_req, i_we, d_req, d_we;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_be, d_be;
    logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
    logic [31:0] i_rdata, d_rdata;
    logic        memory_access, memory_is_writing, external_storage_access, out_valid, arb_idle;
    logic [31:0] addr, d_in, d_out;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;
    int n;

    storage_arbiter #(.ADDR_W(32), .DATA_W(32), .EXT_BASE(EXT), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .prog_mode(prog_mode),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata), .i_be(i_be),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .memory_access(memory_access), .memory_is_writing(memory_is_writing),
        .addr(addr), .d_in(d_in), .mem_be(mem_be),
        .external_storage_access(external_storage_access),
        .d_out(d_out), .out_valid(out_valid), .arb_idle(arb_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; prog_mode = 0; out_valid = 0; d_out = '0;
        i_req = 0; i_we = 0; i_addr = '0; i_wdata = '0; i_be = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        tick(); tick();
        chk("rst_idle", arb_idle, 1);
        chk("rst_macc", memory_access, 0);
        chk("rst_rvalid", {i_rvalid, d_rvalid, i_err, d_err}, 0);
        chk("rst_addr", addr, 0);
        rst = 0;
        tick();
        $display("reset released");

        // Single I read at 0x10, data returns on the third BUSY cycle
        i_req = 1; i_addr = 32'h10; i_be = 4'hF; #1;
        chk("t1_gnt", {i_gnt, d_gnt}, 2'b10);
        tick(); i_req = 0; #1;
        chk("t1_gnt_pulse", i_gnt, 0);
        chk("t1_macc", {memory_access, memory_is_writing, external_storage_access, arb_idle}, 4'b1000);
        chk("t1_addr", addr, 32'h10);
        tick();
        chk("t1_macc2", memory_access, 1);
        tick(); out_valid = 1; d_out = 32'hDEADBEEF; #1;
        chk("t1_macc3", memory_access, 1);
        tick(); out_valid = 0; #1;
        chk("t1_rvalid", {i_rvalid, i_err, d_rvalid}, 3'b100);
        chk("t1_rdata", i_rdata, 32'hDEADBEEF);
        chk("t1_gap", {memory_access, arb_idle}, 2'b00);
        tick();
        chk("t1_idle", {arb_idle, i_rvalid}, 2'b10);
        $display("txn I read 0x10 -> %h", 32'hDEADBEEF);

        // Fresh reset, then both held: grants alternate I, D, I, D
        rst = 1; tick(); rst = 0; tick();
        i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_gnt", {i_gnt, d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick(); out_valid = 1; d_out = 32'hA000_0000 + k; #1;
            chk("rr_nognt", {i_gnt, d_gnt}, 2'b00);
            chk("rr_addr", addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            tick(); out_valid = 0; #1;
            chk("rr_rvalid", {i_rvalid, d_rvalid}, (k % 2 == 0) ? 2'b10 : 2'b01);
            chk("rr_rdata", (k % 2 == 0) ? i_rdata : d_rdata, 32'hA000_0000 + k);
            tick();
            $display("txn rr grant %0d owner=%s", k, (k % 2 == 0) ? "I" : "D");
        end
        i_req = 0; d_req = 0;

        // D read in external space
        d_req = 1; d_we = 0; d_addr = EXT + 4; #1;
        chk("ext_gnt", d_gnt, 1);
        tick(); d_req = 0; #1;
        chk("ext_busy1", {memory_access, external_storage_access}, 2'b11);
        tick(); out_valid = 1; d_out = 32'hCAFE0001; #1;
        chk("ext_busy2", external_storage_access, 1);
        tick(); out_valid = 0; #1;
        chk("ext_done", {d_rvalid, d_err, external_storage_access}, 3'b100);
        chk("ext_rdata", d_rdata, 32'hCAFE0001);
        tick();
        $display("txn D ext read -> %h", d_rdata);

        // D write to external space is refused without a downstream access
        d_req = 1; d_we = 1; d_addr = EXT; d_wdata = 32'h55; #1;
        chk("ew_gnt", d_gnt, 1);
        tick(); d_req = 0; #1;
        chk("ew_err_state", {memory_access, d_rvalid, arb_idle}, 3'b000);
        tick();
        chk("ew_done", {d_rvalid, d_err, memory_access}, 3'b110);
        chk("ew_rdata", d_rdata, 0);
        tick();
        chk("ew_idle", {arb_idle, memory_access}, 2'b10);
        $display("txn D ext write -> err");

        // D SRAM write
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h1234_5678; d_be = 4'hC; #1;
        chk("wr_gnt", d_gnt, 1);
        tick(); d_req = 0; d_we = 0; out_valid = 1; d_out = 32'hFFFF_FFFF; #1;
        chk("wr_ctl", {memory_access, memory_is_writing, external_storage_access}, 3'b110);
        chk("wr_fields", {addr, d_in, 4'h0, mem_be}, {32'h40, 32'h1234_5678, 8'h0C});
        tick(); out_valid = 0; #1;
        chk("wr_done", {d_rvalid, d_err, memory_is_writing}, 3'b100);
        chk("wr_rdata", d_rdata, 0);
        tick();
        $display("txn D write 0x40 be=C");

        // Timeout: no out_valid ever
        i_req = 1; i_we = 0; i_addr = 32'h80; #1;
        chk("to_gnt", i_gnt, 1);
        tick(); i_req = 0; #1;
        chk("to_macc", memory_access, 1);
        n = 0;
        while (!i_rvalid && n < TO + 100) begin
            tick();
            n++;
        end
        chk("to_cycles", n, TO);
        chk("to_err", {i_rvalid, i_err}, 2'b11);
        chk("to_rdata", i_rdata, 0);
        tick();
        chk("to_idle", {arb_idle, memory_access}, 2'b10);
        $display("txn I timeout after %0d cycles", n);

        // prog_mode raised mid-BUSY: completes, pending I held off until prog_mode drops
        d_req = 1; d_we = 0; d_addr = 32'h20; #1;
        chk("pm_gnt", d_gnt, 1);
        tick(); d_req = 0; prog_mode = 1; i_req = 1; i_addr = 32'h30;
        tick(); out_valid = 1; d_out = 32'h0BAD_F00D;
        tick(); out_valid = 0; #1;
        chk("pm_done", {d_rvalid, d_err}, 2'b10);
        chk("pm_rdata", d_rdata, 32'h0BAD_F00D);
        tick();
        chk("pm_block1", {arb_idle, i_gnt}, 2'b10);
        tick();
        chk("pm_block2", i_gnt, 0);
        prog_mode = 0; #1;
        chk("pm_release", i_gnt, 1);
        $display("txn prog_mode hold/release");

        // Reset during BUSY aborts without completion
        tick(); i_req = 0; #1;
        chk("rb_busy", memory_access, 1);
        rst = 1;
        tick();
        chk("rb_abort", {arb_idle, memory_access, i_rvalid}, 3'b100);
        rst = 0;
        tick();
        chk("rb_norv", {i_rvalid, d_rvalid, arb_idle}, 3'b001);
        $display("txn reset mid-BUSY");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
